memory_byte_sequencer: RTL and testbench
========================================

# memory_byte_sequencer

Load/store sequencer between the CPU execute stage and the byte-wide `memory_synth` map (ROM 0x0000_0000, RAM 0x0000_1000). It converts one RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW request into 1, 2 or 4 consecutive single-byte memory cycles, little-endian. For loads it assembles and sign- or zero-extends the 32-bit result, then pulses `done`.

## Interface
- `BASE_IDLE_ADDR`, default 32'h0000_0000, value driven on `mem_address` while idle.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe, accepted only when `busy`=0.
- `address` in 32: byte address of the access; misaligned addresses allowed.
- `write` in 1: 1 = store, 0 = load.
- `funct3` in 3: RISC-V width code. Legal codes:
  - 000 = B
  - 001 = H
  - 010 = W
  - 100 = BU
  - 101 = HU
- `write_value` in 32: store data; the low 8/16/32 bits are used.
- `read_value` out 32: extended load result.
- `busy` out 1: request in flight.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: illegal `funct3`; valid when `done`=1.
- `mem_address` out 32: byte address to `memory_synth`.
- `mem_write_data` out 8: byte to write.
- `mem_write_enable` out 1: write strobe.
- `mem_read_data` in 8: combinational read byte for `mem_address`.

## Operation
- **States:** IDLE, ACCESS, FINISH.
- **IDLE:**
  - `busy`=0.
  - `start`=1 with a legal `funct3` latches `address`, `write`, `funct3` and `write_value`, clears byte counter `idx`, and moves to ACCESS.
  - `start`=1 with an illegal `funct3` (011, 110, 111, or 1xx with `write`=1) moves directly to FINISH with `error` set; no memory cycle occurs.
- **ACCESS:** one byte per cycle, `idx` from 0 to n-1, where n = 1/2/4 from width.
  - `mem_address` = latched address + `idx`, modulo 2^32 (0xFFFF_FFFF wraps to 0).
  - Store: `mem_write_data` = `write_value[8*idx+7 : 8*idx]` and `mem_write_enable`=1. `memory_synth` commits the byte on the same rising edge.
  - Load: `mem_write_enable`=0; `mem_read_data` is captured into byte lane `idx` of the assembly register at the end of the cycle.
  - After `idx`=n-1, go to FINISH.
- **FINISH:**
  - `done`=1 for exactly one cycle, and `busy` stays 1 during this cycle.
  - `read_value` is then valid. It holds until the next accepted `start`.
  - Next state is IDLE.
- **Load extension:**
  - B: sign-extend bit 7.
  - BU: zero-extend.
  - H: sign-extend bit 15.
  - HU: zero-extend.
  - W: pass through unchanged.
- **Store completion:** `read_value` = 0.
- **Error completion:** `read_value` = 0 and `error`=1. `error` clears on the next accepted `start`.
- **`start` while busy:** ignored; no queuing.
- **Memory outputs in IDLE/FINISH:** `mem_address` = `BASE_IDLE_ADDR`, `mem_write_enable`=0, `mem_write_data`=0.
- **Glitch-free strobe:** `mem_write_enable` is decoded from registered state only, never from `start`.

## Timing
- **Reset values:** state IDLE; `busy`, `done`, `error`, `mem_write_enable`, `mem_write_data` and `read_value` all 0; `mem_address` = `BASE_IDLE_ADDR`.
- **Latency:** `start` sampled at edge 0 gives ACCESS in cycles 1..n and `done` in cycle n+1. This is 2/3/5 cycles from the accepting edge to the `done` edge for B/H/W. An illegal request has `done` in cycle 1.
- **Throughput:** a new `start` may be presented in the cycle `done` is high, but is accepted only once `busy`=0 (the following cycle). Back-to-back period is therefore n+2.
- **Reset mid-operation:** asynchronously returns to IDLE and drops `mem_write_enable` immediately. Bytes already written stay in memory (partial store). No `done` is produced.
- **Read timing:** `mem_read_data` must settle within the same cycle as `mem_address`. No wait states are supported.

## Structure
- Add width codes `FUNCT3_B/H/W/BU/HU` to the shared `arch_defines.v` so that decode and this block share them.
- State encodings stay local `localparam`s.
- One natural sub-module: `load_extend`, a combinational 32-bit assembly register plus `funct3`, producing the extended value. It is reusable by a future cached load path.
- Remaining RTL: FSM, 2-bit `idx` counter, request latches, byte-lane mux.

## Test plan
- **SW:** `address`=0x1002, `write_value`=0xDEADBEEF → `mem_write_enable` for 4 cycles at 0x1002..0x1005 with data EF, BE, AD, DE; `done` in cycle 5; `error`=0.
- **LB/LBU:** LB at 0x1005 then LBU at 0x1005 → `read_value` 0xFFFFFFDE, then 0x000000DE; 2-cycle latency each.
- **LH/LHU/LW:** LH at 0x1003 → 0xFFFFADBE; LHU → 0x0000ADBE; LW at 0x1002 → 0xDEADBEEF; ROM read at 0x0 matches the ROM image.
- **Illegal and ignored requests:** `funct3`=011 → `done` one cycle after `start`, `error`=1, no `mem_write_enable` pulse. A `start` asserted while `busy` → no second access.
- **Wrap:** SH at 0xFFFF_FFFF → byte cycles at 0xFFFF_FFFF then 0x0000_0000.
- **Reset mid-operation:** `reset_n` low in the third ACCESS cycle of an SW → all outputs return to reset values asynchronously; bytes 0–1 written, bytes 2–3 not; no `done`.

Source files
------------

// File: rtl/memory_byte_sequencer_pkg.sv
// Shared width codes and request-decode helpers for the byte-wide load/store sequencer.
// The decode stage and the load-extension logic import these so both agree on funct3 meaning.
package memory_byte_sequencer_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    // Unsigned widths only make sense for loads, so 1xx with a store is rejected too.
    function automatic logic funct3_illegal(input logic [2:0] funct3, input logic is_write);
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
               (funct3[2] && is_write);
    endfunction

    // Index of the final byte beat: 0, 1 or 3 for byte, half and word accesses.
    function automatic logic [1:0] last_idx(input logic [2:0] funct3);
        logic [1:0] result;
        case (funct3[1:0])
            2'b00:   result = 2'd0;
            2'b01:   result = 2'd1;
            default: result = 2'd3;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/memory_byte_sequencer_load_extend.sv
// Sign/zero extension of a little-endian assembled load value according to its width code.
// Purely combinational so a future cached load path can reuse it unchanged.
module memory_byte_sequencer_load_extend
    import memory_byte_sequencer_pkg::*;
(
    input  logic [31:0] assembled,
    input  logic [2:0]  funct3,
    output logic [31:0] extended
);

    always_comb begin
        extended = assembled;
        case (funct3)
            FUNCT3_B:  extended = {{24{assembled[7]}}, assembled[7:0]};
            FUNCT3_BU: extended = {24'h000000, assembled[7:0]};
            FUNCT3_H:  extended = {{16{assembled[15]}}, assembled[15:0]};
            FUNCT3_HU: extended = {16'h0000, assembled[15:0]};
            default:   extended = assembled;
        endcase
    end

endmodule

// File: rtl/memory_byte_sequencer.sv
// Splits one RISC-V load/store into 1, 2 or 4 single-byte memory cycles (little-endian)
// and assembles/extends load results, pulsing done once per request.
module memory_byte_sequencer
    import memory_byte_sequencer_pkg::*;
#(
    parameter logic [31:0] BASE_IDLE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] address,
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_value,
    output logic [31:0] read_value,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_write_data,
    output logic        mem_write_enable,
    input  logic [7:0]  mem_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] read_value_q, read_value_d;
    logic        error_q, error_d;

    logic [7:0]  wbyte [0:3];
    logic [31:0] asm_next;
    logic [31:0] load_ext;

    // Lane mux: store lane select and load lane insertion for the current beat.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wbyte[gi] = wdata_q[8*gi +: 8];
            assign asm_next[8*gi +: 8] = (idx_q == 2'(gi)) ? mem_read_data : asm_q[8*gi +: 8];
        end
    endgenerate

    // Extension sees the final byte in the same cycle, so read_value is ready with done.
    memory_byte_sequencer_load_extend u_load_extend (
        .assembled (asm_next),
        .funct3    (funct3_q),
        .extended  (load_ext)
    );

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        write_d          = write_q;
        funct3_d         = funct3_q;
        wdata_d          = wdata_q;
        idx_d            = idx_q;
        asm_d            = asm_q;
        read_value_d     = read_value_q;
        error_d          = error_q;
        busy             = (state_q != ST_IDLE);
        done             = (state_q == ST_FINISH);
        mem_address      = BASE_IDLE_ADDR;
        mem_write_data   = 8'h00;
        mem_write_enable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    error_d      = funct3_illegal(funct3, write);
                    read_value_d = 32'h0;
                    asm_d        = 32'h0;
                    if (funct3_illegal(funct3, write)) begin
                        state_d = ST_FINISH;
                    end else begin
                        addr_d   = address;
                        write_d  = write;
                        funct3_d = funct3;
                        wdata_d  = write_value;
                        idx_d    = 2'd0;
                        state_d  = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                mem_address = addr_q + {30'h0, idx_q};
                if (write_q) begin
                    mem_write_enable = 1'b1;
                    mem_write_data   = wbyte[idx_q];
                end else begin
                    asm_d = asm_next;
                end
                if (idx_q == last_idx(funct3_q)) begin
                    state_d = ST_FINISH;
                    if (!write_q) begin
                        read_value_d = load_ext;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= 32'h0;
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            wdata_q      <= 32'h0;
            idx_q        <= 2'd0;
            asm_q        <= 32'h0;
            read_value_q <= 32'h0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            read_value_q <= read_value_d;
            error_q      <= error_d;
        end
    end

    assign read_value = read_value_q;
    assign error      = error_q;

endmodule

// File: tb/tb_memory_byte_sequencer.sv
// Scoreboard bench: stimulus pushes expected byte writes and completions computed from a
// byte-array memory model; a negedge monitor pops and compares what the sequencer presents.
module tb_memory_byte_sequencer;

    localparam logic [31:0] IDLE_A = 32'h0000_0A40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] address = 32'h0;
    logic        write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] write_value = 32'h0;
    logic [31:0] read_value;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] mem_address;
    logic [7:0]  mem_write_data;
    logic        mem_write_enable;
    logic [7:0]  mem_read_data;

    always #5 clk = ~clk;

    memory_byte_sequencer #(.BASE_IDLE_ADDR(IDLE_A)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .address          (address),
        .write            (write),
        .funct3           (funct3),
        .write_value      (write_value),
        .read_value       (read_value),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    // Memory fixture standing in for memory_synth: ROM below 0x1000, writable above.
    logic [7:0] fix_mem [0:8191];
    logic [7:0] ref_mem [0:8191];
    assign mem_read_data = fix_mem[mem_address[12:0]];
    always @(posedge clk) begin
        if (mem_write_enable && mem_address >= 32'h1000)
            fix_mem[mem_address[12:0]] <= mem_write_data;
    end

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } exp_wr_t;
    typedef struct {
        logic [31:0] rv;
        logic        err;
        int          cyc;
    } exp_done_t;

    exp_wr_t   exp_wr_q[$];
    exp_done_t exp_done_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ntxn = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: compares every byte write and every completion against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_write_enable) begin
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write", mem_address, 32'hFFFF_FFFF);
                end else begin
                    exp_wr_t w;
                    w = exp_wr_q.pop_front();
                    check("wr_addr", mem_address, w.addr);
                    check("wr_data", {24'h0, mem_write_data}, {24'h0, w.data});
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", read_value, 32'hFFFF_FFFF);
                end else begin
                    exp_done_t d;
                    d = exp_done_q.pop_front();
                    ntxn++;
                    $display("txn %0d: read_value=%08h error=%0b cycle=%0d", ntxn, read_value, error, cyc);
                    check("read_value", read_value, d.rv);
                    check("error", {31'h0, error}, {31'h0, d.err});
                    check("done_cycle", cyc, d.cyc);
                    check("busy_in_done", {31'h0, busy}, 32'h1);
                end
            end
            if (!busy) begin
                check("idle_mem_address", mem_address, IDLE_A);
                check("idle_mem_we", {31'h0, mem_write_enable}, 32'h0);
                check("idle_mem_wd", {24'h0, mem_write_data}, 32'h0);
            end
        end
    end

    // Reference model: push expected effects of one request at a higher level of abstraction.
    task automatic model_request(input logic w, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] wv, input int k, input int max_bytes);
        logic        ill;
        int          n;
        logic [31:0] ai;
        logic [31:0] val;
        logic [7:0]  b;
        exp_done_t   d;
        exp_wr_t     ew;
        ill = !(f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || (w && f[2]);
        case (f)
            3'b000, 3'b100: n = 1;
            3'b001, 3'b101: n = 2;
            default:        n = 4;
        endcase
        d.rv = 32'h0;
        d.err = ill;
        d.cyc = ill ? k : k + n;
        if (!ill && w) begin
            for (int i = 0; i < n && i < max_bytes; i++) begin
                ai = a + 32'(i);
                b = 8'(wv >> (8 * i));
                ew.addr = ai;
                ew.data = b;
                exp_wr_q.push_back(ew);
                if (ai >= 32'h1000) ref_mem[ai[12:0]] = b;
            end
        end else if (!ill) begin
            val = 32'h0;
            for (int i = 0; i < n; i++) begin
                ai = a + 32'(i);
                val = val + (32'(ref_mem[ai[12:0]]) << (8 * i));
            end
            if (f == 3'b000 && val >= 32'd128)   val = val - 32'd256;
            if (f == 3'b001 && val >= 32'd32768) val = val - 32'd65536;
            d.rv = val;
        end
        if (max_bytes >= 4) exp_done_q.push_back(d);
    endtask

    task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wv, input logic junk);
        bit finished;
        finished = 0;
        @(negedge clk);
        model_request(w, f, a, wv, cyc + 1, 4);
        start = 1'b1;
        write = w;
        funct3 = f;
        address = a;
        write_value = wv;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done) begin
                start = 1'b0;
                finished = 1;
                break;
            end
            start = junk & 1'($urandom_range(0, 1));
            write = 1'($urandom);
            funct3 = 3'($urandom);
            address = $urandom;
            write_value = $urandom;
        end
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL timeout: no done within 20 cycles for address %08h", a);
            start = 1'b0;
            exp_wr_q.delete();
            exp_done_q.delete();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 32'($urandom_range(0, 255));
            1:       return 32'h1000 + 32'($urandom_range(0, 255));
            default: return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 8192; i++) begin
            fix_mem[i] = rom_byte(i);
            ref_mem[i] = rom_byte(i);
        end

        repeat (2) @(negedge clk);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_error", {31'h0, error}, 32'h0);
        check("reset_mem_we", {31'h0, mem_write_enable}, 32'h0);
        check("reset_mem_wd", {24'h0, mem_write_data}, 32'h0);
        check("reset_read_value", read_value, 32'h0);
        check("reset_mem_address", mem_address, IDLE_A);
        reset_n = 1'b1;

        issue(1'b1, 3'b010, 32'h0000_1002, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 3'b000, 32'h0000_1005, 32'h0, 1'b0);
        issue(1'b0, 3'b100, 32'h0000_1005, 32'h0, 1'b0);
        issue(1'b0, 3'b001, 32'h0000_1003, 32'h0, 1'b0);
        issue(1'b0, 3'b101, 32'h0000_1003, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h0000_1002, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h0000_0000, 32'h0, 1'b0);
        issue(1'b0, 3'b011, 32'h0000_1000, 32'h0, 1'b1);
        issue(1'b1, 3'b100, 32'h0000_1000, 32'h1234_5678, 1'b0);
        issue(1'b1, 3'b010, 32'h0000_1040, 32'hCAFE_F00D, 1'b1);
        issue(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 1'b0);
        issue(1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0, 1'b0);

        for (int r = 0; r < 80; r++) begin
            issue(1'($urandom), 3'($urandom), rand_addr(), $urandom, 1'($urandom));
        end

        // Reset during the third beat of a word store: only bytes 0 and 1 land.
        issue(1'b1, 3'b010, 32'h0000_1010, 32'hAABB_CCDD, 1'b0);
        @(negedge clk);
        model_request(1'b1, 3'b010, 32'h0000_1010, 32'h1122_3344, 0, 2);
        start = 1'b1;
        write = 1'b1;
        funct3 = 3'b010;
        address = 32'h0000_1010;
        write_value = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_busy", {31'h0, busy}, 32'h0);
        check("midreset_done", {31'h0, done}, 32'h0);
        check("midreset_error", {31'h0, error}, 32'h0);
        check("midreset_mem_we", {31'h0, mem_write_enable}, 32'h0);
        check("midreset_mem_wd", {24'h0, mem_write_data}, 32'h0);
        check("midreset_read_value", read_value, 32'h0);
        check("midreset_mem_address", mem_address, IDLE_A);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(1'b0, 3'b010, 32'h0000_1010, 32'h0, 1'b0);

        repeat (2) @(negedge clk);
        check("pending_writes", 32'(exp_wr_q.size()), 32'h0);
        check("pending_dones", 32'(exp_done_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
